// File: rtl/servo_pwm_ramp.sv
// Dual-channel hobby-servo PWM generator. Each channel's pulse width is clamped
// to a safe range and slewed toward its target by a bounded step once per frame.
module servo_pwm_ramp #(
    parameter int unsigned CLK_HZ    = 100_000_000,
    parameter int unsigned PERIOD_US = 20000,
    parameter int unsigned MIN_US    = 1000,
    parameter int unsigned MAX_US    = 2000,
    parameter int unsigned STEP_US   = 10
) (
    input  logic        sys_clock,
    input  logic        reset,
    input  logic        enable,
    input  logic        tgt_wr,
    input  logic        tgt_ch,
    input  logic [15:0] tgt_us,
    output logic        pwm0_0,
    output logic        pwm0_1,
    output logic [15:0] cur_us_0,
    output logic [15:0] cur_us_1,
    output logic [1:0]  settled,
    output logic        frame_start
);

    localparam int unsigned DIV  = CLK_HZ / 1_000_000;
    localparam int unsigned PS_W = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic [PS_W-1:0] PS_LAST     = PS_W'(DIV - 1);
    localparam logic [15:0]     PERIOD_LAST = 16'(PERIOD_US - 1);
    localparam logic [15:0]     MIN_W       = 16'(MIN_US);
    localparam logic [15:0]     MAX_W       = 16'(MAX_US);
    localparam logic [15:0]     STEP_W      = 16'(STEP_US);
    localparam logic [15:0]     CENTER      = 16'((MIN_US + MAX_US) / 2);

    logic [PS_W-1:0]  presc;
    logic [15:0]      frame_cnt;
    logic [1:0][15:0] tgt;
    logic [1:0][15:0] cur;
    logic [1:0][15:0] nxt_cur;
    logic [1:0]       pwm;
    logic             us_tick;
    logic             boundary;

    function automatic logic [15:0] clamp_us(input logic [15:0] v);
        if (v < MIN_W) return MIN_W;
        if (v > MAX_W) return MAX_W;
        return v;
    endfunction

    // Distance is taken as larger minus smaller so no signed arithmetic is needed.
    function automatic logic [15:0] ramp_step(input logic [15:0] c, input logic [15:0] t);
        logic        up;
        logic [15:0] d;
        up = (t >= c);
        d  = up ? (t - c) : (c - t);
        if (STEP_US == 0 || d <= STEP_W) return t;
        return up ? (c + STEP_W) : (c - STEP_W);
    endfunction

    assign us_tick  = (presc == PS_LAST);
    assign boundary = us_tick && (frame_cnt == PERIOD_LAST);

    // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
    always_comb begin
        nxt_cur = cur;
        for (int ch = 0; ch < 2; ch++) begin
            nxt_cur[ch] = ramp_step(cur[ch], tgt[ch]);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge sys_clock) begin
        if (reset) begin
            presc       <= '0;
            frame_cnt   <= '0;
            tgt         <= {CENTER, CENTER};
            cur         <= {CENTER, CENTER};
            pwm         <= '0;
            settled     <= 2'b11;
            frame_start <= 1'b0;
        end else begin
            presc <= us_tick ? '0 : presc + 1'b1;
            if (us_tick) begin
                frame_cnt <= boundary ? 16'd0 : frame_cnt + 16'd1;
            end

            // A write landing on the boundary edge is seen by the following frame's ramp.
            if (tgt_wr) begin
                tgt[tgt_ch] <= clamp_us(tgt_us);
            end
            if (boundary) begin
                cur <= nxt_cur;
            end

            // Outputs keep running counters when disabled so re-enable lands in phase.
            for (int ch = 0; ch < 2; ch++) begin
                pwm[ch]     <= enable && (frame_cnt < cur[ch]);
                settled[ch] <= (cur[ch] == tgt[ch]);
            end
            frame_start <= boundary;
        end
    end

    assign pwm0_0   = pwm[0];
    assign pwm0_1   = pwm[1];
    assign cur_us_0 = cur[0];
    assign cur_us_1 = cur[1];

endmodule

// File: tb/tb_servo_pwm_ramp.sv
// Directed bench for servo_pwm_ramp: DIV=2, 100 us frames (200 cycles), 10..50 us clamp,
// step 5. A second instance with step 0 shares the inputs to show immediate jumps.
module tb_servo_pwm_ramp;

    logic        sys_clock;
    logic        reset;
    logic        enable;
    logic        tgt_wr;
    logic        tgt_ch;
    logic [15:0] tgt_us;

    logic        pwm0_0, pwm0_1, frame_start;
    logic [15:0] cur_us_0, cur_us_1;
    logic [1:0]  settled;

    logic        z_pwm0_0, z_pwm0_1, z_frame_start;
    logic [15:0] z_cur_us_0, z_cur_us_1;
    logic [1:0]  z_settled;

    int checks = 0;
    int passes = 0;

    servo_pwm_ramp #(
        .CLK_HZ(2_000_000), .PERIOD_US(100), .MIN_US(10), .MAX_US(50), .STEP_US(5)
    ) dut (
        .sys_clock(sys_clock), .reset(reset), .enable(enable),
        .tgt_wr(tgt_wr), .tgt_ch(tgt_ch), .tgt_us(tgt_us),
        .pwm0_0(pwm0_0), .pwm0_1(pwm0_1),
        .cur_us_0(cur_us_0), .cur_us_1(cur_us_1),
        .settled(settled), .frame_start(frame_start)
    );

    servo_pwm_ramp #(
        .CLK_HZ(2_000_000), .PERIOD_US(100), .MIN_US(10), .MAX_US(50), .STEP_US(0)
    ) dut0 (
        .sys_clock(sys_clock), .reset(reset), .enable(enable),
        .tgt_wr(tgt_wr), .tgt_ch(tgt_ch), .tgt_us(tgt_us),
        .pwm0_0(z_pwm0_0), .pwm0_1(z_pwm0_1),
        .cur_us_0(z_cur_us_0), .cur_us_1(z_cur_us_1),
        .settled(z_settled), .frame_start(z_frame_start)
    );

    initial sys_clock = 1'b0;
    always #5 sys_clock = ~sys_clock;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Advances to the next negedge where frame_start is high; n = negedges taken.
    task automatic wait_frame(output int n);
        n = 0;
        do begin
            @(negedge sys_clock);
            n++;
        end while (!frame_start && n < 400);
        checks++;
        if (frame_start !== 1'b1) $display("FAIL frame_start_timeout: got %0d expected 1 within 400 cycles", frame_start);
        else passes++;
    endtask

    task automatic count_pwm(input int cycles, output int h0, output int h1);
        h0 = 0;
        h1 = 0;
        repeat (cycles) begin
            @(negedge sys_clock);
            h0 += int'(pwm0_0);
            h1 += int'(pwm0_1);
        end
    endtask

    task automatic write_tgt(input logic ch, input logic [15:0] us);
        tgt_wr = 1'b1;
        tgt_ch = ch;
        tgt_us = us;
        @(negedge sys_clock);
        tgt_wr = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge sys_clock);
        checks++; if (cur_us_0 !== 16'd30) $display("FAIL rst_cur0: got %0d expected 30", cur_us_0); else passes++;
        checks++; if (cur_us_1 !== 16'd30) $display("FAIL rst_cur1: got %0d expected 30", cur_us_1); else passes++;
        checks++; if (settled !== 2'b11) $display("FAIL rst_settled: got %b expected 11", settled); else passes++;
        checks++; if ({pwm0_1, pwm0_0} !== 2'b00) $display("FAIL rst_pwm: got %b expected 00", {pwm0_1, pwm0_0}); else passes++;
        checks++; if (frame_start !== 1'b0) $display("FAIL rst_frame_start: got %0d expected 0", frame_start); else passes++;
        checks++; if (z_cur_us_1 !== 16'd30) $display("FAIL rst_z_cur1: got %0d expected 30", z_cur_us_1); else passes++;
        reset  = 1'b0;
        enable = 1'b1;
    endtask

    task automatic test_center();
        int n, h0, h1;
        wait_frame(n);
        checks++; if (n !== 200) $display("FAIL first_frame_len: got %0d expected 200", n); else passes++;
        checks++; if (cur_us_0 !== 16'd30 || cur_us_1 !== 16'd30) $display("FAIL center_cur: got %0d/%0d expected 30/30", cur_us_0, cur_us_1); else passes++;
        checks++; if (settled !== 2'b11) $display("FAIL center_settled: got %b expected 11", settled); else passes++;
        count_pwm(200, h0, h1);
        checks++; if (h0 !== 60) $display("FAIL center_high0: got %0d expected 60", h0); else passes++;
        checks++; if (h1 !== 60) $display("FAIL center_high1: got %0d expected 60", h1); else passes++;
        checks++; if (frame_start !== 1'b1) $display("FAIL center_period: got %0d expected 1 after 200 cycles", frame_start); else passes++;
    endtask

    task automatic test_ramp_up();
        int n, h0, h1;
        logic [15:0] exp_cur;
        write_tgt(1'b0, 16'd50);
        @(negedge sys_clock);
        checks++; if (settled !== 2'b10) $display("FAIL ramp_unsettled: got %b expected 10", settled); else passes++;
        for (int i = 0; i < 4; i++) begin
            exp_cur = 16'(35 + 5 * i);
            wait_frame(n);
            checks++; if (cur_us_0 !== exp_cur) $display("FAIL ramp_cur0_step%0d: got %0d expected %0d", i, cur_us_0, exp_cur); else passes++;
            checks++; if (cur_us_1 !== 16'd30) $display("FAIL ramp_cur1_step%0d: got %0d expected 30", i, cur_us_1); else passes++;
            if (i == 0) begin
                checks++; if (z_cur_us_0 !== 16'd50) $display("FAIL ramp_z_jump: got %0d expected 50", z_cur_us_0); else passes++;
            end
            @(negedge sys_clock);
            checks++; if (settled[0] !== (i == 3)) $display("FAIL ramp_settled_step%0d: got %0d expected %0d", i, settled[0], (i == 3)); else passes++;
        end
        wait_frame(n);
        count_pwm(200, h0, h1);
        checks++; if (h0 !== 100) $display("FAIL ramp_high0: got %0d expected 100", h0); else passes++;
        checks++; if (h1 !== 60) $display("FAIL ramp_high1: got %0d expected 60", h1); else passes++;
    endtask

    task automatic test_back_to_back();
        int n;
        tgt_wr = 1'b1; tgt_ch = 1'b1; tgt_us = 16'd5;
        @(negedge sys_clock);
        tgt_us = 16'd1000;
        @(negedge sys_clock);
        tgt_wr = 1'b0;
        wait_frame(n);
        checks++; if (cur_us_1 !== 16'd35) $display("FAIL b2b_cur1: got %0d expected 35", cur_us_1); else passes++;
        checks++; if (z_cur_us_1 !== 16'd50) $display("FAIL b2b_z_cur1: got %0d expected 50", z_cur_us_1); else passes++;
        checks++; if (cur_us_0 !== 16'd50) $display("FAIL b2b_cur0: got %0d expected 50", cur_us_0); else passes++;
        write_tgt(1'b1, 16'd5);
        wait_frame(n);
        checks++; if (cur_us_1 !== 16'd30) $display("FAIL clamp_lo_cur1: got %0d expected 30", cur_us_1); else passes++;
        checks++; if (z_cur_us_1 !== 16'd10) $display("FAIL clamp_lo_z_cur1: got %0d expected 10", z_cur_us_1); else passes++;
        write_tgt(1'b1, 16'd30);
        wait_frame(n);
        checks++; if (z_cur_us_1 !== 16'd30) $display("FAIL restore_z_cur1: got %0d expected 30", z_cur_us_1); else passes++;
        @(negedge sys_clock);
        checks++; if (settled !== 2'b11) $display("FAIL restore_settled: got %b expected 11", settled); else passes++;
        wait_frame(n);
    endtask

    task automatic test_boundary_write();
        int n;
        write_tgt(1'b0, 16'd10);
        wait_frame(n);
        checks++; if (cur_us_0 !== 16'd45) $display("FAIL bnd_pre_cur0: got %0d expected 45", cur_us_0); else passes++;
        repeat (199) @(negedge sys_clock);
        write_tgt(1'b0, 16'd50);
        checks++; if (frame_start !== 1'b1) $display("FAIL bnd_align: got %0d expected 1", frame_start); else passes++;
        checks++; if (cur_us_0 !== 16'd40) $display("FAIL bnd_old_tgt: got %0d expected 40", cur_us_0); else passes++;
        wait_frame(n);
        checks++; if (cur_us_0 !== 16'd45) $display("FAIL bnd_new_tgt: got %0d expected 45", cur_us_0); else passes++;
    endtask

    task automatic test_enable();
        int n, h0, h1, g0, g1;
        repeat (20) @(negedge sys_clock);
        checks++; if (pwm0_0 !== 1'b1) $display("FAIL en_mid_pulse: got %0d expected 1", pwm0_0); else passes++;
        enable = 1'b0;
        @(negedge sys_clock);
        checks++; if ({pwm0_1, pwm0_0} !== 2'b00) $display("FAIL en_drop: got %b expected 00", {pwm0_1, pwm0_0}); else passes++;
        wait_frame(n);
        checks++; if (n !== 179) $display("FAIL en_period: got %0d expected 179", n); else passes++;
        checks++; if (cur_us_0 !== 16'd50) $display("FAIL en_ramp_continues: got %0d expected 50", cur_us_0); else passes++;
        count_pwm(100, h0, h1);
        enable = 1'b1;
        count_pwm(100, g0, g1);
        checks++; if (h0 + h1 + g0 + g1 !== 0) $display("FAIL en_low_frame: got %0d high cycles expected 0", h0 + h1 + g0 + g1); else passes++;
        checks++; if (frame_start !== 1'b1) $display("FAIL en_period2: got %0d expected 1", frame_start); else passes++;
        count_pwm(200, h0, h1);
        checks++; if (h0 !== 100) $display("FAIL en_resume0: got %0d expected 100", h0); else passes++;
        checks++; if (h1 !== 60) $display("FAIL en_resume1: got %0d expected 60", h1); else passes++;
        checks++; if (frame_start !== 1'b1) $display("FAIL en_resume_align: got %0d expected 1", frame_start); else passes++;
    endtask

    task automatic test_reset_mid_ramp();
        int n, h0, h1;
        write_tgt(1'b0, 16'd10);
        wait_frame(n);
        checks++; if (cur_us_0 !== 16'd45) $display("FAIL mid_pre_cur0: got %0d expected 45", cur_us_0); else passes++;
        repeat (10) @(negedge sys_clock);
        write_tgt(1'b0, 16'd50);
        repeat (30) @(negedge sys_clock);
        reset = 1'b1;
        @(negedge sys_clock);
        reset = 1'b0;
        checks++; if (cur_us_0 !== 16'd30) $display("FAIL mid_rst_cur0: got %0d expected 30", cur_us_0); else passes++;
        checks++; if (settled !== 2'b11) $display("FAIL mid_rst_settled: got %b expected 11", settled); else passes++;
        checks++; if ({pwm0_1, pwm0_0} !== 2'b00) $display("FAIL mid_rst_pwm: got %b expected 00", {pwm0_1, pwm0_0}); else passes++;
        n = 0; h0 = 0; h1 = 0;
        do begin
            @(negedge sys_clock);
            n++;
            h0 += int'(pwm0_0);
            h1 += int'(pwm0_1);
        end while (!frame_start && n < 400);
        checks++; if (n !== 200) $display("FAIL mid_rst_restart: got %0d expected 200", n); else passes++;
        checks++; if (h0 !== 60 || h1 !== 60) $display("FAIL mid_rst_high: got %0d/%0d expected 60/60", h0, h1); else passes++;
    endtask

    initial begin
        reset  = 1'b1;
        enable = 1'b0;
        tgt_wr = 1'b0;
        tgt_ch = 1'b0;
        tgt_us = 16'd0;
        test_reset();
        test_center();
        test_ramp_up();
        test_back_to_back();
        test_boundary_write();
        test_enable();
        test_reset_mid_ramp();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/servo_pwm_ramp.md
# servo_pwm_ramp

Dual-channel hobby-servo PWM generator with per-frame slew limiting. It sits directly downstream of the processor GPIO output register and drives the two JB servo pins (`pwm0_0`, `pwm0_1`). Firmware writes a target pulse width in microseconds. The block clamps that target to a safe range and ramps each channel's actual pulse width toward it by at most `STEP_US` per PWM frame, so the sorting arm never jerks.

## Interface
Parameters:
- `CLK_HZ`, 100_000_000: `sys_clock` frequency. Must be a multiple of 1_000_000. `DIV = CLK_HZ/1_000_000`.
- `PERIOD_US`, 20000: frame length in µs. Must be < 65536.
- `MIN_US`, 1000: lower clamp on pulse width.
- `MAX_US`, 2000: upper clamp. `MIN_US <= MAX_US < PERIOD_US`.
- `STEP_US`, 10: maximum width change per frame. 0 means jump immediately to target.

Ports:
- `sys_clock`  in  1  system clock
- `reset`  in  1  synchronous, active-high reset
- `enable`  in  1  1 = outputs active; 0 = both PWM outputs forced low
- `tgt_wr`  in  1  single-cycle write strobe
- `tgt_ch`  in  1  channel select for the write (0 or 1)
- `tgt_us`  in  16  requested pulse width in µs (unsigned)
- `pwm0_0`  out  1  channel 0 servo pulse
- `pwm0_1`  out  1  channel 1 servo pulse
- `cur_us_0`  out  16  channel 0 width currently being generated
- `cur_us_1`  out  16  channel 1 width currently being generated
- `settled`  out  2  bit n = 1 when `cur_us_n` equals the channel n target
- `frame_start`  out  1  one-cycle pulse on each frame wrap

## Operation
- Reset values:
  - prescaler = 0, `frame_cnt` = 0.
  - Both targets and both `cur_us` = CENTER = (MIN_US+MAX_US)/2.
  - `pwm0_*` = 0, `frame_start` = 0, `settled` = 2'b11.
- Prescaler counts 0..DIV-1. `us_tick` asserts in the cycle where the prescaler = DIV-1.
- `frame_cnt` (16 bits, counts µs):
  - On `us_tick`, increments.
  - On `us_tick` while `frame_cnt` = PERIOD_US-1, wraps to 0. Call this the *boundary*.
- Target write:
  - On `tgt_wr`, `tgt[tgt_ch]` <= clamp(`tgt_us`, MIN_US, MAX_US).
  - No backpressure. Every strobe is accepted.
- Ramp, applied at each boundary for each channel independently:
  - d = |tgt − cur|, computed as larger minus smaller (no signed overflow).
  - If d <= STEP_US or STEP_US = 0: cur <= tgt.
  - Otherwise: cur <= cur ± STEP_US, moving toward tgt.
- PWM:
  - `pwm0_n` (registered) = `enable` && (`frame_cnt` < `cur_us_n`).
  - High time is exactly `cur_us_n`·DIV cycles per frame of PERIOD_US·DIV cycles.
- `settled[n]` (registered) = (`cur_us_n` == `tgt[n]`).
- `frame_start` (registered) pulses once, in the cycle after the boundary.
- `enable` = 0:
  - Outputs are low.
  - Prescaler, `frame_cnt` and ramping continue, so re-enabling resumes in phase.
- Simultaneous events:
  - Write in the same cycle as a boundary: the ramp uses the pre-write target. The new target takes effect at the following boundary.
  - Two writes to the same channel on consecutive cycles: the last one wins.

## Timing
- Target register updates on the edge after `tgt_wr`.
- `cur_us_n` changes only on the edge that performs the boundary wrap.
- `pwm0_n`:
  - Rises on the edge after `frame_cnt` becomes 0.
  - Falls on the edge after `frame_cnt` reaches `cur_us_n`.
  - One-cycle pipeline relative to `frame_cnt`. Both channels are aligned.
- Worst-case settle time: ceil((MAX_US−MIN_US)/STEP_US) frames.
- `reset` asserted mid-frame or mid-ramp: on the next edge, every register takes its reset value. `pwm0_*` is low the following cycle.

## Test plan
All scenarios use CLK_HZ=2_000_000 (DIV=2), PERIOD_US=100, MIN_US=10, MAX_US=50, STEP_US=5. CENTER = 30.
- Release reset, hold `enable`=1 → both pwm high for 60 cycles of every 200-cycle frame; `cur_us_*`=30; `settled`=2'b11.
- Write ch0=50 → `cur_us_0` steps 35, 40, 45, 50 on four successive `frame_start`; `settled[0]`=0 until 50; then 100-cycle pulse. Channel 1 unchanged.
- Write ch1=5, then ch1=1000 → target captured as 10, then 50. STEP_US=0 build: `cur_us_1` jumps 30→50 in one boundary.
- Write ch0=40 in the exact boundary cycle → no change at that boundary; `cur_us_0`=35 at the next.
- Drop `enable` mid-pulse → pwm low next cycle; `frame_start` period stays at 200 cycles. Re-raise → pulse starts at the next frame, correctly aligned.
- Assert `reset` while `cur_us_0`=45 ramping to 50 → `cur_us_0`=30, `settled`=2'b11, `frame_cnt` restarts at 0.
